// File: rtl/ws281x_pkg.sv
// ws281x_pkg: default 50 MHz timing, FSM state type and counter-width helper for the WS281X encoder.
package ws281x_pkg;

    localparam int DEF_T0H_CYC    = 12;
    localparam int DEF_T1H_CYC    = 31;
    localparam int DEF_TBIT_CYC   = 62;
    localparam int DEF_TLATCH_CYC = 2500;

    typedef enum logic [2:0] {IDLE, HIGH, LOW, GAP, LATCH} state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ws281x_bit_timer.sv
// ws281x_bit_timer: loadable down-counter whose terminal count ends each timed encoder phase.
module ws281x_bit_timer
    import ws281x_pkg::*;
#(
    parameter int W = cnt_width(DEF_TLATCH_CYC)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign tc = (count == '0);

endmodule

// File: rtl/ws281x_encoder.sv
// ws281x_encoder: valid/ready pixel words to a timed WS281X bitstream, MSB first, latch gap per frame.
// Optional WS281X_GRB_EN: swap bytes [23:16] and [15:8] so RGB input leaves as GRB.
module ws281x_encoder
    import ws281x_pkg::*;
#(
    parameter int BITS_PER_PIXEL = 24,
    parameter int NUM_PIXELS     = 7,
    parameter int T0H_CYC        = DEF_T0H_CYC,
    parameter int T1H_CYC        = DEF_T1H_CYC,
    parameter int TBIT_CYC       = DEF_TBIT_CYC,
    parameter int TLATCH_CYC     = DEF_TLATCH_CYC
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic [BITS_PER_PIXEL-1:0] PixelData,
    input  logic                      PixelValid,
    output logic                      PixelReady,
    output logic                      Dout,
    output logic                      Busy,
    output logic                      FrameDone,
    output logic                      Underrun
);

    localparam int BPP = BITS_PER_PIXEL;
    localparam int TW  = cnt_width(TLATCH_CYC);
    localparam int PW  = cnt_width(NUM_PIXELS);
    localparam int BW  = cnt_width(BPP - 1);

    if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC && TBIT_CYC <= TLATCH_CYC)) begin : g_bad_timing
        $error("ws281x_encoder: timing must satisfy 0 < T0H_CYC < T1H_CYC < TBIT_CYC <= TLATCH_CYC");
    end
    if (!(BPP == 24 || BPP == 32) || NUM_PIXELS < 1 || NUM_PIXELS > 4095) begin : g_bad_shape
        $error("ws281x_encoder: BITS_PER_PIXEL must be 24 or 32 and NUM_PIXELS 1..4095");
    end

    state_t          state, state_nx;
    logic            run, hold_full, accept, load, advance, tload, tc;
    logic            last_bit, frame_end, bit_nx, done_nx, under_nx;
    logic [BPP-1:0]  hold_q, shift_q, load_word;
    logic [PW-1:0]   px_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [TW-1:0]   tval;

`ifdef WS281X_GRB_EN
    always_comb begin
        load_word        = hold_q;
        load_word[23:16] = hold_q[15:8];
        load_word[15:8]  = hold_q[23:16];
    end
`else
    assign load_word = hold_q;
`endif

    // run keeps PixelReady low until the first edge after reset is released
    assign PixelReady = run && state != LATCH && (!hold_full || load);
    assign accept     = PixelValid && PixelReady;
    assign Busy       = state != IDLE;
    assign last_bit   = bit_cnt == BW'(BPP - 1);
    assign frame_end  = px_cnt == PW'(NUM_PIXELS - 1);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        advance  = 1'b0;
        tload    = 1'b0;
        tval     = '0;
        done_nx  = 1'b0;
        under_nx = 1'b0;
        bit_nx   = shift_q[BPP-1];
        case (state)
            IDLE: if (hold_full) begin
                load     = 1'b1;
                state_nx = HIGH;
            end
            HIGH: if (tc) begin
                state_nx = LOW;
                tload    = 1'b1;
                tval     = TW'(TBIT_CYC - (shift_q[BPP-1] ? T1H_CYC : T0H_CYC) - 1);
            end
            LOW: if (tc) begin
                if (!last_bit) begin
                    advance  = 1'b1;
                    state_nx = HIGH;
                end else if (frame_end) begin
                    state_nx = LATCH;
                    tload    = 1'b1;
                    tval     = TW'(TLATCH_CYC - 1);
                end else if (hold_full) begin
                    load     = 1'b1;
                    state_nx = HIGH;
                end else begin
                    state_nx = GAP;
                    tload    = 1'b1;
                    tval     = TW'(TLATCH_CYC - 1);
                    under_nx = 1'b1;
                end
            end
            GAP: if (hold_full) begin
                load     = 1'b1;
                state_nx = HIGH;
            end else if (tc) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            LATCH: if (tc) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // every entry into HIGH times the high phase from the bit about to be sent
        if (load || advance) begin
            tload  = 1'b1;
            bit_nx = load ? load_word[BPP-1] : shift_q[BPP-2];
            tval   = bit_nx ? TW'(T1H_CYC - 1) : TW'(T0H_CYC - 1);
        end
    end

    ws281x_bit_timer #(.W(TW)) u_timer (
        .clk      (Clock),
        .rst_n    (Reset_n),
        .load     (tload),
        .load_val (tval),
        .tc       (tc)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            run       <= 1'b0;
            hold_full <= 1'b0;
            hold_q    <= '0;
            shift_q   <= '0;
            bit_cnt   <= '0;
            px_cnt    <= '0;
            Dout      <= 1'b0;
            FrameDone <= 1'b0;
            Underrun  <= 1'b0;
        end else begin
            state     <= state_nx;
            run       <= 1'b1;
            hold_full <= accept || (hold_full && !load);
            Dout      <= state == HIGH;
            FrameDone <= done_nx;
            Underrun  <= under_nx;
            if (accept)
                hold_q <= PixelData;
            if (load)
                shift_q <= load_word;
            else if (advance)
                shift_q <= shift_q << 1;
            bit_cnt <= load ? '0 : advance ? bit_cnt + BW'(1) : bit_cnt;
            px_cnt  <= done_nx ? '0 : (state == LOW && tc && last_bit) ? px_cnt + PW'(1) : px_cnt;
        end
    end

endmodule

// File: tb/tb_ws281x_encoder.sv
// tb_ws281x_encoder: randomized pixels scored by a pulse-timing decoder of Dout against a queue of expected words.
module tb_ws281x_encoder;

    localparam int BPP    = 24;
    localparam int NPX    = 7;
    localparam int T0H    = 12;
    localparam int T1H    = 31;
    localparam int TBIT   = 62;
    localparam int TLATCH = 2500;

    logic           Clock = 1'b0;
    logic           Reset_n = 1'b1;
    logic [BPP-1:0] PixelData = '0;
    logic           PixelValid = 1'b0;
    logic           PixelReady, Dout, Busy, FrameDone, Underrun;

    int n_cmp = 0;
    int n_bad = 0;
    int ud_cnt = 0;
    int fd_cnt = 0;
    logic [BPP-1:0] exp_q[$];

    ws281x_encoder #(
        .BITS_PER_PIXEL (BPP),
        .NUM_PIXELS     (NPX),
        .T0H_CYC        (T0H),
        .T1H_CYC        (T1H),
        .TBIT_CYC       (TBIT),
        .TLATCH_CYC     (TLATCH)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .PixelData  (PixelData),
        .PixelValid (PixelValid),
        .PixelReady (PixelReady),
        .Dout       (Dout),
        .Busy       (Busy),
        .FrameDone  (FrameDone),
        .Underrun   (Underrun)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // order in which a pixel's bits should appear on the wire
    function automatic logic [BPP-1:0] wire_order(input logic [BPP-1:0] d);
        logic [BPP-1:0] r;
        r = d;
`ifdef WS281X_GRB_EN
        r = {d[15:8], d[23:16], d[7:0]};
`endif
        return r;
    endfunction

    // Monitor: decodes every bit from its high width and checks timing of periods, Underrun and FrameDone.
    logic prev_d = 1'b0, have_rise = 1'b0, gap_flag = 1'b0, last_final = 1'b0, ud_seen = 1'b0, rise;
    int since = 0, hi_len = 0, bit_idx = 0, frame_px = 0;
    logic [BPP-1:0] cur_w = '0, got_w = '0;

    always @(negedge Clock) begin
        if (!Reset_n) begin
            prev_d = 1'b0; have_rise = 1'b0; gap_flag = 1'b0; last_final = 1'b0; ud_seen = 1'b0;
            since = 0; hi_len = 0; bit_idx = 0; frame_px = 0;
        end else begin
            since++;
            rise = Dout && !prev_d;
            if (last_final && since == TBIT && frame_px < NPX)
                chk("underrun_vs_next_bit", int'(ud_seen), int'(!rise));
            if (Underrun) begin
                ud_cnt++;
                ud_seen = 1'b1;
                gap_flag = 1'b1;
                chk("underrun_timing", int'(last_final && frame_px < NPX && since == TBIT - 1), 1);
            end
            if (FrameDone || (last_final && since == TBIT + TLATCH - 1))
                chk("frame_done_timing", int'(FrameDone), int'(last_final && since == TBIT + TLATCH - 1));
            if (FrameDone) begin
                fd_cnt++;
                frame_px = 0;
                last_final = 1'b0;
                gap_flag = 1'b1;
            end
            if (rise) begin
                if (have_rise && !gap_flag)
                    chk("bit_period", since, TBIT);
                if (last_final)
                    chk("rise_only_within_frame", int'(frame_px < NPX), 1);
                if (bit_idx == 0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pixel", exp_q.size(), 1);
                        cur_w = '0;
                    end else begin
                        cur_w = exp_q.pop_front();
                    end
                    got_w = '0;
                end
                have_rise = 1'b1; gap_flag = 1'b0; last_final = 1'b0; ud_seen = 1'b0;
                since = 0; hi_len = 0;
            end
            if (Dout)
                hi_len++;
            if (!Dout && prev_d) begin
                chk("high_width", hi_len, cur_w[BPP-1-bit_idx] ? T1H : T0H);
                got_w = {got_w[BPP-2:0], hi_len > (T0H + T1H) / 2};
                bit_idx++;
                if (bit_idx == BPP) begin
                    chk("pixel_word", int'(got_w), int'(cur_w));
                    bit_idx = 0;
                    frame_px++;
                    last_final = 1'b1;
                end
            end
            prev_d = Dout;
        end
    end

    task automatic send(input logic [BPP-1:0] d);
        int t;
        t = 0;
        PixelData = d;
        PixelValid = 1'b1;
        while (!PixelReady && t < 20000) begin
            @(negedge Clock);
            t++;
        end
        if (!PixelReady) begin
            chk("ready_timeout", int'(PixelReady), 1);
            PixelValid = 1'b0;
        end else begin
            exp_q.push_back(wire_order(d));
            @(posedge Clock);
            @(negedge Clock);
        end
    endtask

    task automatic wait_underrun();
        int t;
        t = 0;
        PixelValid = 1'b0;
        while (!Underrun && t < 10000) begin
            @(negedge Clock);
            t++;
        end
        chk("underrun_seen", int'(Underrun), 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        PixelValid = 1'b0;
        while ((Busy || exp_q.size() != 0) && t < 30000) begin
            @(negedge Clock);
            t++;
        end
        chk("idle_reached", int'(Busy), 0);
        @(negedge Clock);
    endtask

    task automatic stall_low(input int n);
        int highs;
        highs = 0;
        PixelValid = 1'b0;
        repeat (n) begin
            @(negedge Clock);
            highs += int'(Dout);
        end
        chk("dout_low_while_stalled", highs, 0);
    endtask

    initial begin
        #15_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ud0, fd0;
        logic [BPP-1:0] fixed_px[NPX];
        fixed_px = '{24'hAA0000, 24'h00BB00, 24'h0000CC, 24'h555555, 24'h000000, 24'hFFFFFF, 24'h123456};
        #1 Reset_n = 1'b0;
        repeat (3) @(negedge Clock);
        chk("reset_dout", int'(Dout), 0);
        chk("reset_ready", int'(PixelReady), 0);
        chk("reset_busy", int'(Busy), 0);
        chk("reset_framedone", int'(FrameDone), 0);
        chk("reset_underrun", int'(Underrun), 0);
        Reset_n = 1'b1;
        #1 chk("ready_before_first_edge", int'(PixelReady), 0);
        @(posedge Clock);
        #1 chk("ready_after_first_edge", int'(PixelReady), 1);
        @(negedge Clock);

        // full frame, PixelValid held high
        ud0 = ud_cnt; fd0 = fd_cnt;
        foreach (fixed_px[i]) send(fixed_px[i]);
        wait_idle();
        chk("frame1_framedone_count", fd_cnt - fd0, 1);
        chk("frame1_underrun_count", ud_cnt - ud0, 0);

        // random frame with a short stall after pixel 3
        ud0 = ud_cnt; fd0 = fd_cnt;
        for (int i = 0; i < 3; i++) send(BPP'($urandom()));
        wait_underrun();
        stall_low(100 + $urandom_range(0, 40));
        for (int i = 0; i < 4; i++) send(BPP'($urandom()));
        wait_idle();
        chk("stall_underrun_count", ud_cnt - ud0, 1);
        chk("stall_framedone_count", fd_cnt - fd0, 1);

        // single pixel: Dout latency, then abort after the gap
        ud0 = ud_cnt; fd0 = fd_cnt;
        send(24'h800001);
        PixelValid = 1'b0;
        chk("dout_latency_e0", int'(Dout), 0);
        @(negedge Clock);
        chk("dout_latency_e1", int'(Dout), 0);
        @(negedge Clock);
        chk("dout_latency_e2", int'(Dout), 1);
        wait_underrun();
        wait_idle();
        chk("single_underrun_count", ud_cnt - ud0, 1);
        chk("single_framedone_count", fd_cnt - fd0, 1);

        // long stall aborts the frame; the next pixels start a fresh frame
        ud0 = ud_cnt; fd0 = fd_cnt;
        for (int i = 0; i < 3; i++) send(BPP'($urandom()));
        wait_underrun();
        stall_low(3000);
        chk("abort_framedone_count", fd_cnt - fd0, 1);
        for (int i = 0; i < NPX; i++) send(BPP'($urandom()));
        wait_idle();
        chk("abort_underrun_count", ud_cnt - ud0, 1);
        chk("abort_framedone_total", fd_cnt - fd0, 2);

        // reset in the middle of a high phase discards shifting and held pixels
        send(24'hFFFFFF);
        send(24'hFFFFFF);
        PixelValid = 1'b0;
        for (int t = 0; t < 100 && !Dout; t++) @(negedge Clock);
        chk("reset_test_dout_high", int'(Dout), 1);
        repeat (19) @(posedge Clock);
        #2 Reset_n = 1'b0;
        #1;
        chk("midbit_reset_dout", int'(Dout), 0);
        chk("midbit_reset_ready", int'(PixelReady), 0);
        chk("midbit_reset_busy", int'(Busy), 0);
        exp_q.delete();
        repeat (3) @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1 chk("ready_after_midbit_reset", int'(PixelReady), 1);
        @(negedge Clock);
        ud0 = ud_cnt; fd0 = fd_cnt;
        send(BPP'($urandom()));
        wait_underrun();
        wait_idle();
        repeat (200) @(negedge Clock);
        chk("post_reset_queue_drained", exp_q.size(), 0);
        chk("post_reset_framedone_count", fd_cnt - fd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
